// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B, then decodes Gray steps.
// Define QUAD_X4_EN for x4 counting (every legal step); default build counts x1 (one step per cycle).
module quad_encoder_decoder #(
  parameter int FILT_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       en,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       err_tick,
  output logic [1:0] ab_state
);

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [4:0] SETTLE   = 5'(FILT_LEN + 3);

  logic       r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic       r_a_f, r_b_f;
  logic [3:0] r_a_cnt, r_b_cnt;
  logic [4:0] r_settle;
  logic [1:0] r_prev;
  logic       r_cnt_en, r_cnt_up, r_err_tick;

  logic [1:0] w_cur;
  logic       w_armed, w_live;
  logic       w_fwd, w_rev, w_err;
  logic       w_cntFwd, w_cntRev, w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_s1 <= 1'b0;
      r_a_s2 <= 1'b0;
      r_b_s1 <= 1'b0;
      r_b_s2 <= 1'b0;
    end else begin
      r_a_s1 <= a_in;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= b_in;
      r_b_s2 <= r_b_s1;
    end
  end

  // Decoding stays disarmed until the synchronizers and filters have settled after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle <= 5'd0;
    end else if (r_settle != SETTLE) begin
      r_settle <= r_settle + 5'd1;
    end
  end

  assign w_armed = (r_settle == SETTLE);
  assign w_live  = w_armed & en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_f   <= 1'b0;
      r_a_cnt <= 4'd0;
    end else if (!w_armed) begin
      r_a_f   <= r_a_s2;
      r_a_cnt <= 4'd0;
    end else if (r_a_s2 == r_a_f) begin
      r_a_cnt <= 4'd0;
    end else if (r_a_cnt == FILT_MAX) begin
      r_a_f   <= r_a_s2;
      r_a_cnt <= 4'd0;
    end else begin
      r_a_cnt <= r_a_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b_f   <= 1'b0;
      r_b_cnt <= 4'd0;
    end else if (!w_armed) begin
      r_b_f   <= r_b_s2;
      r_b_cnt <= 4'd0;
    end else if (r_b_s2 == r_b_f) begin
      r_b_cnt <= 4'd0;
    end else if (r_b_cnt == FILT_MAX) begin
      r_b_f   <= r_b_s2;
      r_b_cnt <= 4'd0;
    end else begin
      r_b_cnt <= r_b_cnt + 4'd1;
    end
  end

  assign w_cur = {r_a_f, r_b_f};
  assign w_err = &(w_cur ^ r_prev);

  // Gray order 00 -> 01 -> 11 -> 10 -> 00 is the forward (up) direction.
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    case (r_prev)
      2'b00: begin w_fwd = (w_cur == 2'b01); w_rev = (w_cur == 2'b10); end
      2'b01: begin w_fwd = (w_cur == 2'b11); w_rev = (w_cur == 2'b00); end
      2'b11: begin w_fwd = (w_cur == 2'b10); w_rev = (w_cur == 2'b01); end
      default: begin w_fwd = (w_cur == 2'b00); w_rev = (w_cur == 2'b11); end
    endcase
  end

`ifdef QUAD_X4_EN
  assign w_cntFwd = w_fwd;
  assign w_cntRev = w_rev;
`else
  assign w_cntFwd = w_fwd & (r_prev == 2'b10);
  assign w_cntRev = w_rev & (r_prev == 2'b00);
`endif

  assign w_count = w_cntFwd | w_cntRev;

  // While disarmed prev tracks the synchronized inputs so arming never sees a stale step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev     <= 2'b00;
      r_cnt_en   <= 1'b0;
      r_err_tick <= 1'b0;
      r_cnt_up   <= 1'b0;
    end else begin
      r_prev     <= w_armed ? w_cur : {r_a_s2, r_b_s2};
      r_cnt_en   <= w_live & w_count;
      r_err_tick <= w_live & w_err;
      if (w_live & w_count) begin
        r_cnt_up <= w_cntFwd;
      end
    end
  end

  assign cnt_en   = r_cnt_en;
  assign cnt_up   = r_cnt_up;
  assign err_tick = r_err_tick;
  assign ab_state = w_cur;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Self-checking bench for quad_encoder_decoder: directed scenarios plus randomized encoder
// traffic, every cycle compared against a history-based reference model.
module tb_quad_encoder_decoder;

  localparam int FILT_LEN = 8;

`ifdef QUAD_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       en = 1'b1;
  logic       cnt_en, cnt_up, err_tick;
  logic [1:0] ab_state;

  int checkCount = 0;
  int failCount  = 0;
  int pulseCnt   = 0;
  int errCnt     = 0;

  // Reference model state: raw-sample delay line, filtered levels and the last decoded pair.
  int edgeCnt;
  bit rawA1, rawA2, rawB1, rawB2;
  bit mA, mB, prevA, prevB;
  bit expEn, expErr, expUp;
  bit histA[$], histB[$];
  int posOf[4];
  int curAb;

  quad_encoder_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .en(en),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .err_tick(err_tick), .ab_state(ab_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    edgeCnt = 0;
    rawA1 = 0; rawA2 = 0; rawB1 = 0; rawB2 = 0;
    mA = 0; mB = 0; prevA = 0; prevB = 0;
    expEn = 0; expErr = 0; expUp = 0;
    histA.delete();
    histB.delete();
  endtask

  // A filtered level flips once FILT_LEN consecutive samples since its last flip disagree with it.
  function automatic bit runDisagrees(input bit hist[$], input bit level);
    if (hist.size() < FILT_LEN) return 1'b0;
    for (int k = hist.size() - FILT_LEN; k < hist.size(); k++)
      if (hist[k] == level) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelEdge();
    bit sA, sB, armed, counted;
    int prevAb, nowAb, delta;
    edgeCnt++;
    armed = edgeCnt > FILT_LEN + 3;
    sA = rawA2; sB = rawB2;
    rawA2 = rawA1; rawB2 = rawB1;
    rawA1 = a_in;  rawB1 = b_in;
    if (!armed) begin
      expEn = 0; expErr = 0;
      mA = sA; mB = sB;
      prevA = sA; prevB = sB;
      histA.delete();
      histB.delete();
    end else begin
      prevAb = {prevA, prevB};
      nowAb  = {mA, mB};
      delta  = (posOf[nowAb] - posOf[prevAb] + 4) % 4;
      if (X4) counted = (delta == 1) || (delta == 3);
      else    counted = (delta == 1 && nowAb == 0) || (delta == 3 && prevAb == 0);
      expEn  = en && counted;
      expErr = en && (delta == 2);
      if (en && counted) expUp = (delta == 1);
      prevA = mA; prevB = mB;
      histA.push_back(sA);
      histB.push_back(sB);
      if (runDisagrees(histA, mA)) begin mA = ~mA; histA.delete(); end
      if (runDisagrees(histB, mB)) begin mB = ~mB; histB.delete(); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset) modelEdge();
    checkOutput("cnt_en", cnt_en, expEn);
    checkOutput("err_tick", err_tick, expErr);
    checkOutput("cnt_up", cnt_up, expUp);
    checkOutput("ab_state", ab_state, {mA, mB});
    if (cnt_en) pulseCnt++;
    if (err_tick) errCnt++;
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit e, input int n);
    @(negedge clk);
    a_in = a; b_in = b; en = e;
    curAb = {a, b};
    repeat (n) tick();
  endtask

  task automatic applyReset(input int n, input bit a, input bit b);
    @(negedge clk);
    reset = 1'b1;
    a_in = a; b_in = b;
    curAb = {a, b};
    modelReset();
    #1;
    checkOutput("rstAsync", {cnt_en, cnt_up, err_tick, ab_state}, 0);
    repeat (n) tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic clearCounts();
    pulseCnt = 0;
    errCnt = 0;
  endtask

  initial begin
    int kind, hold, p, len;
    bit e;
    posOf = '{0, 1, 3, 2};
    modelReset();
    #1;
    checkOutput("rstInit", {cnt_en, cnt_up, err_tick, ab_state}, 0);
    applyReset(3, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 20);

    clearCounts();
    applyStimulus(0, 1, 1, 20);
    applyStimulus(1, 1, 1, 20);
    applyStimulus(1, 0, 1, 20);
    applyStimulus(0, 0, 1, 20);
    checkOutput("fwdPulses", pulseCnt, X4 ? 4 : 1);
    checkOutput("fwdDir", cnt_up, 1);

    clearCounts();
    applyStimulus(1, 0, 1, 20);
    applyStimulus(1, 1, 1, 20);
    applyStimulus(0, 1, 1, 20);
    applyStimulus(0, 0, 1, 20);
    checkOutput("revPulses", pulseCnt, X4 ? 4 : 1);
    checkOutput("revDir", cnt_up, 0);

    clearCounts();
    applyStimulus(1, 0, 1, FILT_LEN - 1);
    applyStimulus(0, 0, 1, 20);
    checkOutput("glitchPulses", pulseCnt, 0);
    checkOutput("glitchAb", ab_state, 0);
    applyStimulus(1, 0, 1, FILT_LEN);
    applyStimulus(0, 0, 1, 30);
    checkOutput("minWidthPulses", pulseCnt, 2);

    clearCounts();
    applyStimulus(1, 1, 1, 20);
    checkOutput("dblErr", errCnt, 1);
    checkOutput("dblPulses", pulseCnt, 0);
    checkOutput("dblDir", cnt_up, 1);

    clearCounts();
    applyReset(3, 1'b1, 1'b1);
    applyStimulus(1, 1, 1, 30);
    checkOutput("armErr", errCnt, 0);
    checkOutput("armPulses", pulseCnt, 0);
    checkOutput("armAb", ab_state, 3);
    applyStimulus(1, 0, 1, 20);
    checkOutput("postArmPulses", pulseCnt, X4 ? 1 : 0);
    checkOutput("postArmDir", cnt_up, X4 ? 1 : 0);

    applyStimulus(0, 0, 1, 20);
    clearCounts();
    applyStimulus(0, 1, 0, 20);
    applyStimulus(1, 1, 0, 20);
    checkOutput("enOffPulses", pulseCnt, 0);
    applyStimulus(1, 0, 1, 20);
    checkOutput("enOnPulses", pulseCnt, X4 ? 1 : 0);
    checkOutput("enErr", errCnt, 0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) applyReset($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 25);
      e = ($urandom_range(0, 5) != 0);
      p = posOf[curAb];
      if (kind <= 6) begin
        p = ($urandom_range(0, 1) != 0) ? (p + 1) % 4 : (p + 3) % 4;
        len = posOf[p];
        applyStimulus(len[1], len[0], e, hold);
      end else if (kind == 7) begin
        len = curAb ^ 3;
        applyStimulus(len[1], len[0], e, hold);
      end else begin
        len = curAb ^ (($urandom_range(0, 1) != 0) ? 2 : 1);
        p = curAb;
        applyStimulus(len[1], len[0], e, $urandom_range(1, FILT_LEN - 1));
        applyStimulus(p[1], p[0], e, hold);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
